// File: rtl/dnn_pkg.sv
// Shared types and defaults for the dnn_top feed sequencer.
// Defaults mirror the reference dnn_top build.
package dnn_pkg;

    localparam int BIT_SIZE   = 4;
    localparam int W_BIT_SIZE = 4;
    localparam int NUM_IN     = 2;
    localparam int MAX_NERVES = 3;
    localparam int NUM_IMAGES = 2;
    localparam int IMAGE_SIZE = 4;
    localparam int NUM_W_ROWS = 7;

    typedef logic [MAX_NERVES*W_BIT_SIZE-1:0] weight_row_t;
    typedef logic [NUM_IN*BIT_SIZE-1:0]       pixel_beat_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        FEED,
        PAD,
        DRAIN
    } feed_state_t;

    // Counter width that never collapses to zero bits.
    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dnn_feed_sequencer_if.sv
// Weight memory, pixel stream and dnn_top signals of the sequencer.
// master = sequencer side, slave = environment side.
interface dnn_feed_sequencer_if #(
    parameter int AddrW       = 3,
    parameter int RowW        = 12,
    parameter int PixW        = 8,
    parameter int NumOfImages = 2
);
    logic [AddrW-1:0]       w_addr;
    logic                   w_rd_en;
    logic [RowW-1:0]        w_rd_data;
    logic                   pix_valid;
    logic                   pix_ready;
    logic [PixW-1:0]        pix_data;
    logic                   dnn_res_n;
    logic [RowW-1:0]        dnn_weights;
    logic [NumOfImages-1:0] dnn_in_valid;
    logic [PixW-1:0]        dnn_in_data;
    logic                   dnn_out_ready;
    logic                   dnn_out_done;

    modport master (
        output w_addr, w_rd_en,
        input  w_rd_data,
        input  pix_valid, pix_data,
        output pix_ready,
        output dnn_res_n, dnn_weights, dnn_in_valid,
        output dnn_in_data, dnn_out_ready,
        input  dnn_out_done
    );

    modport slave (
        input  w_addr, w_rd_en,
        output w_rd_data,
        output pix_valid, pix_data,
        input  pix_ready,
        input  dnn_res_n, dnn_weights, dnn_in_valid,
        input  dnn_in_data, dnn_out_ready,
        output dnn_out_done
    );

endinterface

// File: rtl/dnn_weight_streamer.sv
// Walks the weight memory once and aligns returned rows
// with a valid flag; rows outside a valid read are forced to zero.
module dnn_weight_streamer #(
    parameter int NumWeightRows = 7,
    parameter int RowW          = 12,
    parameter int AddrW         = 3
) (
    input  logic             clk,
    input  logic             res,
    input  logic             go,
    output logic [AddrW-1:0] w_addr,
    output logic             w_rd_en,
    input  logic [RowW-1:0]  w_rd_data,
    output logic [RowW-1:0]  weights,
    output logic             row_valid,
    output logic             last_row
);

    localparam logic [AddrW-1:0] LastAddr = AddrW'(NumWeightRows - 1);

    logic [AddrW-1:0] row_cnt;

    always_ff @(posedge clk) begin
        if (res) begin
            w_addr    <= '0;
            w_rd_en   <= 1'b0;
            row_valid <= 1'b0;
            row_cnt   <= '0;
        end else begin
            // memory returns data one cycle after the enable
            row_valid <= w_rd_en;
            if (go) begin
                w_rd_en <= 1'b1;
                w_addr  <= '0;
            end else if (w_rd_en) begin
                if (w_addr == LastAddr)
                    w_rd_en <= 1'b0;
                else
                    w_addr <= w_addr + 1'b1;
            end
            if (go)
                row_cnt <= '0;
            else if (row_valid)
                row_cnt <= row_cnt + 1'b1;
        end
    end

    assign weights  = row_valid ? w_rd_data : '0;
    assign last_row = row_valid && (row_cnt == LastAddr);

endmodule

// File: rtl/dnn_feed_sequencer.sv
// Drives one dnn_top run: weight load, pixel feed, padding,
// then waits for out_done before returning to idle.
module dnn_feed_sequencer
    import dnn_pkg::*;
#(
    parameter int BitSize        = 4,
    parameter int M_W_BitSize    = 4,
    parameter int NumIn          = 2,
    parameter int MaxNumNerves   = 3,
    parameter int NumOfImages    = 2,
    parameter int ImageSize      = 4,
    parameter int NumWeightRows  = 7,
    parameter int CyclesPerPixel = 1
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    dnn_feed_sequencer_if.master  bus
);

    localparam int RowW  = MaxNumNerves * M_W_BitSize;
    localparam int PixW  = NumIn * BitSize;
    localparam int AddrW = cw(NumWeightRows);
    localparam int BeatW = $clog2(ImageSize + 1);
    localparam int HoldW = $clog2(CyclesPerPixel + 1);
    localparam int PadW  = cw(NumOfImages);

    localparam logic [BeatW-1:0] LastBeat = BeatW'(ImageSize);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(CyclesPerPixel - 1);
    localparam logic [PadW-1:0]  PadLast  =
        PadW'((NumOfImages > 1) ? NumOfImages - 2 : 0);

    feed_state_t      state;
    logic [BeatW-1:0] beat_cnt;
    logic [HoldW-1:0] hold_cnt;
    logic [PadW-1:0]  pad_cnt;
    logic [BeatW-1:0] beat_nxt;
    logic [HoldW-1:0] hold_nxt;
    logic             go;
    logic             row_valid;
    logic             last_row;
    logic             holding;

    assign go       = (state == IDLE) && start;
    assign beat_nxt = beat_cnt + 1'b1;
    assign hold_nxt = hold_cnt + 1'b1;
    assign holding  = |bus.dnn_in_valid;

    dnn_weight_streamer #(
        .NumWeightRows (NumWeightRows),
        .RowW          (RowW),
        .AddrW         (AddrW)
    ) u_streamer (
        .clk       (clk),
        .res       (res),
        .go        (go),
        .w_addr    (bus.w_addr),
        .w_rd_en   (bus.w_rd_en),
        .w_rd_data (bus.w_rd_data),
        .weights   (bus.dnn_weights),
        .row_valid (row_valid),
        .last_row  (last_row)
    );

    always_ff @(posedge clk) begin
        if (res) begin
            state             <= IDLE;
            busy              <= 1'b0;
            done              <= 1'b0;
            bus.pix_ready     <= 1'b0;
            bus.dnn_res_n     <= 1'b0;
            bus.dnn_in_valid  <= '0;
            bus.dnn_in_data   <= '0;
            bus.dnn_out_ready <= 1'b0;
            beat_cnt          <= '0;
            hold_cnt          <= '0;
            pad_cnt           <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD_W;
                        busy  <= 1'b1;
                    end
                end
                LOAD_W: begin
                    if (row_valid)
                        bus.dnn_res_n <= 1'b1;
                    if (last_row) begin
                        state         <= FEED;
                        bus.pix_ready <= 1'b1;
                        beat_cnt      <= '0;
                        hold_cnt      <= '0;
                    end
                end
                FEED: begin
                    if (holding && hold_cnt != HoldLast) begin
                        hold_cnt      <= hold_nxt;
                        // ready sits on the last hold cycle so beats abut
                        bus.pix_ready <= (hold_nxt == HoldLast) &&
                                         (beat_cnt != LastBeat);
                    end else if (holding && beat_cnt == LastBeat) begin
                        bus.dnn_in_data <= '0;
                        pad_cnt         <= '0;
                        if (NumOfImages > 1) begin
                            state            <= PAD;
                            bus.dnn_in_valid <= '1;
                        end else begin
                            state             <= DRAIN;
                            bus.dnn_in_valid  <= '0;
                            bus.dnn_out_ready <= 1'b1;
                        end
                    end else if (bus.pix_valid && bus.pix_ready) begin
                        bus.dnn_in_valid <= '1;
                        bus.dnn_in_data  <= bus.pix_data;
                        hold_cnt         <= '0;
                        beat_cnt         <= beat_nxt;
                        bus.pix_ready    <= (HoldLast == '0) &&
                                            (beat_nxt != LastBeat);
                    end else begin
                        bus.dnn_in_valid <= '0;
                        bus.dnn_in_data  <= '0;
                        bus.pix_ready    <= 1'b1;
                    end
                end
                PAD: begin
                    if (pad_cnt == PadLast) begin
                        state             <= DRAIN;
                        bus.dnn_in_valid  <= '0;
                        bus.dnn_out_ready <= 1'b1;
                    end else begin
                        pad_cnt <= pad_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (bus.dnn_out_done) begin
                        state             <= IDLE;
                        busy              <= 1'b0;
                        done              <= 1'b1;
                        bus.dnn_out_ready <= 1'b0;
                        bus.dnn_res_n     <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dnn_feed_sequencer.sv
// Bench for dnn_feed_sequencer: a 1-cycle and a 2-cycle-hold build
// checked against a stream-level model of the expected dnn_top traffic.
module tb_dnn_feed_sequencer;
    import dnn_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        res;
    logic        st;
    logic        pv;
    pixel_beat_t pd;
    logic        od;
    logic        sel;
    logic        start_a, start_b;
    logic        busy_a, busy_b, done_a, done_b;
    weight_row_t rd_a, rd_b;
    weight_row_t mem [7];

    int total = 0;
    int bad   = 0;

    dnn_feed_sequencer_if #(.AddrW(3), .RowW(12), .PixW(8),
                            .NumOfImages(2)) bus_a ();
    dnn_feed_sequencer_if #(.AddrW(3), .RowW(12), .PixW(8),
                            .NumOfImages(2)) bus_b ();

    dnn_feed_sequencer #(.CyclesPerPixel(1)) dut_a (
        .clk   (clk),
        .res   (res),
        .start (start_a),
        .busy  (busy_a),
        .done  (done_a),
        .bus   (bus_a.master)
    );

    dnn_feed_sequencer #(.CyclesPerPixel(2)) dut_b (
        .clk   (clk),
        .res   (res),
        .start (start_b),
        .busy  (busy_b),
        .done  (done_b),
        .bus   (bus_b.master)
    );

    always @(posedge clk) begin
        if (bus_a.w_rd_en) rd_a <= mem[bus_a.w_addr];
        if (bus_b.w_rd_en) rd_b <= mem[bus_b.w_addr];
    end

    assign bus_a.w_rd_data    = rd_a;
    assign bus_b.w_rd_data    = rd_b;
    assign bus_a.pix_valid    = pv;
    assign bus_b.pix_valid    = pv;
    assign bus_a.pix_data     = pd;
    assign bus_b.pix_data     = pd;
    assign bus_a.dnn_out_done = od;
    assign bus_b.dnn_out_done = od;
    assign start_a = st && !sel;
    assign start_b = st && sel;

    logic        o_busy, o_done, o_rden, o_resn, o_ready, o_oready;
    logic [2:0]  o_addr;
    weight_row_t o_w;
    logic [1:0]  o_v;
    pixel_beat_t o_d;

    always_comb begin
        o_busy   = sel ? busy_b : busy_a;
        o_done   = sel ? done_b : done_a;
        o_rden   = sel ? bus_b.w_rd_en : bus_a.w_rd_en;
        o_addr   = sel ? bus_b.w_addr : bus_a.w_addr;
        o_resn   = sel ? bus_b.dnn_res_n : bus_a.dnn_res_n;
        o_ready  = sel ? bus_b.pix_ready : bus_a.pix_ready;
        o_oready = sel ? bus_b.dnn_out_ready : bus_a.dnn_out_ready;
        o_w      = sel ? bus_b.dnn_weights : bus_a.dnn_weights;
        o_v      = sel ? bus_b.dnn_in_valid : bus_a.dnn_in_valid;
        o_d      = sel ? bus_b.dnn_in_data : bus_a.dnn_in_data;
    end

    task automatic chk(input string nm, input int t,
                       input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s@%0d: got %0h want %0h", nm, t, act, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"},  0, 32'(o_busy),   0);
        chk({tag, "_done"},  0, 32'(o_done),   0);
        chk({tag, "_rden"},  0, 32'(o_rden),   0);
        chk({tag, "_addr"},  0, 32'(o_addr),   0);
        chk({tag, "_ready"}, 0, 32'(o_ready),  0);
        chk({tag, "_resn"},  0, 32'(o_resn),   0);
        chk({tag, "_valid"}, 0, 32'(o_v),      0);
        chk({tag, "_data"},  0, 32'(o_d),      0);
        chk({tag, "_w"},     0, 32'(o_w),      0);
        chk({tag, "_oready"},0, 32'(o_oready), 0);
    endtask

    // One full run. Expected dnn_in traffic is the plain concatenation:
    // one idle cycle, then per beat its withheld cycles and cpp copies,
    // then one pad cycle; weights appear on samples 1..7 from start.
    task automatic run(input logic s, input logic [3:0][1:0] dl,
                       input logic [3:0][7:0] bt, output int rc);
        int cpp;
        int len;
        int dr;
        int last;
        logic [1:0]  ev [$];
        pixel_beat_t ed [$];
        cpp = s ? 2 : 1;
        ev.push_back(2'b00); ed.push_back('0);
        for (int i = 0; i < 4; i++) begin
            repeat (int'(dl[i])) begin
                ev.push_back(2'b00); ed.push_back('0);
            end
            repeat (cpp) begin
                ev.push_back(2'b11); ed.push_back(bt[i]);
            end
        end
        ev.push_back(2'b11); ed.push_back('0);
        len  = ev.size();
        dr   = 8 + len;
        last = dr + 7;
        sel  = s;
        rc   = 0;
        @(negedge clk); st = 1'b1;
        @(negedge clk); st = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    int rem;
                    bit off;
                    int g;
                    rem = int'(dl[i]);
                    off = 1'b0;
                    g   = 0;
                    while (!off && g < 300) begin
                        if (o_ready && rem > 0) begin
                            pv = 1'b0;
                            rem--;
                        end else begin
                            pv = 1'b1;
                            pd = bt[i];
                            if (o_ready) off = 1'b1;
                        end
                        @(negedge clk);
                        g++;
                    end
                end
                pv = 1'b0;
                pd = '0;
            end
            begin
                for (int t = 0; t <= last; t++) begin
                    weight_row_t ew;
                    logic [1:0]  xv;
                    pixel_beat_t xd;
                    ew = (t >= 1 && t <= 7) ? mem[t-1] : '0;
                    xv = (t >= 8 && t < dr) ? ev[t-8] : 2'b00;
                    xd = (t >= 8 && t < dr) ? ed[t-8] : '0;
                    chk("weights", t, 32'(o_w), 32'(ew));
                    chk("res_n", t, 32'(o_resn),
                        32'(t >= 2 && t <= dr + 4));
                    chk("busy", t, 32'(o_busy), 32'(t <= dr + 4));
                    chk("done", t, 32'(o_done), 32'(t == dr + 5));
                    chk("out_ready", t, 32'(o_oready),
                        32'(t >= dr && t <= dr + 4));
                    chk("in_valid", t, 32'(o_v), 32'(xv));
                    chk("in_data", t, 32'(o_d), 32'(xd));
                    if (t <= 7) begin
                        chk("rd_en", t, 32'(o_rden), 32'(t <= 6));
                        if (t <= 6) chk("addr", t, 32'(o_addr), 32'(t));
                    end
                    if (t < 8 || t >= dr - 1)
                        chk("pix_ready_off", t, 32'(o_ready), 0);
                    if (o_ready) rc++;
                    od = (t == dr + 4);
                    st = (t == dr + 1) || (t == dr + 4);
                    @(negedge clk);
                end
                od = 1'b0;
                st = 1'b0;
            end
        join
    endtask

    typedef struct packed {
        logic            sel;
        logic [3:0][1:0] dl;
        logic [3:0][7:0] bt;
        logic [3:0]      exp_ready;
    } vec_t;

    vec_t tbl [4];

    initial begin
        int rc;
        int n;
        int g;
        logic            rs;
        logic [3:0][1:0] rdl;
        logic [3:0][7:0] rbt;
        int              sum;

        mem[0] = 12'h120; mem[1] = 12'h300; mem[2] = 12'h300;
        mem[3] = 12'h130; mem[4] = 12'h303; mem[5] = 12'h230;
        mem[6] = 12'h100;

        tbl[0] = '{sel: 1'b0, dl: 8'h00, bt: 32'h1123_3012,
                   exp_ready: 4'd4};
        tbl[1] = '{sel: 1'b0, dl: 8'h20, bt: 32'h1123_3012,
                   exp_ready: 4'd6};
        tbl[2] = '{sel: 1'b1, dl: 8'h00, bt: 32'h1123_3012,
                   exp_ready: 4'd4};
        tbl[3] = '{sel: 1'b1, dl: 8'h11, bt: 32'h9c4e_07f5,
                   exp_ready: 4'd6};

        res = 1'b1; st = 1'b0; pv = 1'b0; pd = '0; od = 1'b0;
        sel = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle("rst_a");
        sel = 1'b1;
        chk_idle("rst_b");
        res = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            run(tbl[i].sel, tbl[i].dl, tbl[i].bt, rc);
            chk("ready_pulses", i, 32'(rc), 32'(tbl[i].exp_ready));
        end

        // abort in the middle of the pixel feed
        sel = 1'b0;
        pv  = 1'b1;
        pd  = 8'h5a;
        @(negedge clk); st = 1'b1;
        @(negedge clk); st = 1'b0;
        n = 0;
        g = 0;
        while (n < 2 && g < 100) begin
            if (o_v == 2'b11) n++;
            @(negedge clk);
            g++;
        end
        chk("abort_reach", g, 32'(n), 2);
        res = 1'b1;
        @(negedge clk);
        chk_idle("abort");
        res = 1'b0;
        pv  = 1'b0;
        pd  = '0;
        run(tbl[0].sel, tbl[0].dl, tbl[0].bt, rc);
        chk("ready_after_abort", 0, 32'(rc), 4);

        for (int r = 0; r < 6; r++) begin
            rs  = 1'($urandom_range(0, 1));
            sum = 0;
            for (int i = 0; i < 4; i++) begin
                rdl[i] = 2'($urandom_range(0, 2));
                rbt[i] = 8'($urandom);
                sum += int'(rdl[i]);
            end
            run(rs, rdl, rbt, rc);
            chk("ready_rand", r, 32'(rc), 32'(4 + sum));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
